// File: rtl/uart_rx_framer.sv
// uart_rx_framer: 16x-oversampled UART receive framer.
//   Finds a start bit, samples each bit at mid-bit (counter = 7), shifts in
//   5-8 data bits LSB first, optionally checks parity, samples one stop bit,
//   then strobes valid_o for one cycle with the word and error flags.
// Ports:
//   clk_i, nrst_i        clock, async active-low reset
//   tick_i               16x baud enable (one clk_i cycle wide)
//   rxd_i                deglitched serial line, idle high
//   wls_i/pen_i/eps_i/sp_i  word length, parity enable, even select, stick parity
//   data_o               received word, right-justified, zero-filled MSBs
//   valid_o              one-cycle strobe qualifying data_o and the flags
//   perr_o/ferr_o/brk_o  parity, framing and break flags
//   busy_o               high whenever the FSM is not IDLE
// Build option: define UART_RX_BREAK_DETECT_EN to enable break detection.
module uart_rx_framer (
   input  logic       clk_i,
   input  logic       nrst_i,
   input  logic       tick_i,
   input  logic       rxd_i,
   input  logic [1:0] wls_i,
   input  logic       pen_i,
   input  logic       eps_i,
   input  logic       sp_i,
   output logic [7:0] data_o,
   output logic       valid_o,
   output logic       perr_o,
   output logic       ferr_o,
   output logic       brk_o,
   output logic       busy_o
);

   localparam int unsigned CNT_W  = 4;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned IDX_W  = 3;
   localparam int unsigned MID    = 7;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t              state;
   logic [CNT_W-1:0]    cnt;
   logic [DATA_W-1:0]   shreg;
   logic [IDX_W-1:0]    bit_idx;
   logic [1:0]          wls_q;
   logic                pen_q;
   logic                eps_q;
   logic                sp_q;
   logic                par_q;
   logic                mid;
   logic                exp_par;
   logic                start_ok;
   logic [IDX_W-1:0]    last_idx;

   // Mid-bit sample point of the current bit
   assign mid = tick_i && (cnt == CNT_W'(MID));

   // Index of the last data bit: 4 + wls (5..8 bits)
   assign last_idx = {1'b1, wls_q};

   // Expected parity bit; unused shreg MSBs are zero so they do not disturb the XOR
   assign exp_par = sp_q ? ~eps_q : (eps_q ? ^shreg : ~^shreg);

`ifdef UART_RX_BREAK_DETECT_EN
   logic brk_hold;
   logic brk_now;

   // Break: every data bit, the parity bit (when present) and the stop bit are 0
   assign brk_now  = (shreg == '0) && (!pen_q || !par_q) && !rxd_i;
   // After a break the line must return high before a new start is accepted
   assign start_ok = !rxd_i && !brk_hold;
`else
   assign start_ok = !rxd_i;
   assign brk_o    = 1'b0;
`endif

   // Framer FSM, oversample counter and registered outputs
   always_ff @(posedge clk_i or negedge nrst_i) begin
      if (!nrst_i) begin
         state    <= IDLE;
         cnt      <= '0;
         shreg    <= '0;
         bit_idx  <= '0;
         wls_q    <= '0;
         pen_q    <= 1'b0;
         eps_q    <= 1'b0;
         sp_q     <= 1'b0;
         par_q    <= 1'b0;
         data_o   <= '0;
         valid_o  <= 1'b0;
         perr_o   <= 1'b0;
         ferr_o   <= 1'b0;
         busy_o   <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
         brk_o    <= 1'b0;
         brk_hold <= 1'b0;
`endif
      end else begin
         valid_o <= 1'b0;
         if (tick_i) begin
            cnt <= cnt + CNT_W'(1);
            case (state)
               IDLE: begin
`ifdef UART_RX_BREAK_DETECT_EN
                  if (rxd_i) brk_hold <= 1'b0;
`endif
                  if (start_ok) begin
                     // Frame settings are frozen here for the whole frame
                     state   <= START;
                     busy_o  <= 1'b1;
                     cnt     <= '0;
                     shreg   <= '0;
                     bit_idx <= '0;
                     wls_q   <= wls_i;
                     pen_q   <= pen_i;
                     eps_q   <= eps_i;
                     sp_q    <= sp_i;
                  end
               end
               START: begin
                  if (mid) begin
                     if (rxd_i) begin
                        state  <= IDLE;   // false start
                        busy_o <= 1'b0;
                     end else begin
                        state  <= DATA;
                     end
                  end
               end
               DATA: begin
                  if (mid) begin
                     shreg[bit_idx] <= rxd_i;
                     bit_idx        <= bit_idx + IDX_W'(1);
                     if (bit_idx == last_idx) state <= pen_q ? PARITY : STOP;
                  end
               end
               PARITY: begin
                  if (mid) begin
                     par_q <= rxd_i;
                     state <= STOP;
                  end
               end
               STOP: begin
                  // Leave at mid-stop: the remaining half bit is resync margin
                  if (mid) begin
                     state   <= IDLE;
                     busy_o  <= 1'b0;
                     valid_o <= 1'b1;
                     data_o  <= shreg;
                     perr_o  <= pen_q && (par_q != exp_par);
                     ferr_o  <= !rxd_i;
`ifdef UART_RX_BREAK_DETECT_EN
                     brk_o    <= brk_now;
                     brk_hold <= brk_now;
`endif
                  end
               end
               default: begin
                  state  <= IDLE;
                  busy_o <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_framer.sv
// tb_uart_rx_framer: directed self-checking bench for uart_rx_framer.
//   Ticks are one clk wide, every third cycle. Inputs change on negedge,
//   outputs are sampled on negedge. Break expectations follow
//   UART_RX_BREAK_DETECT_EN.
module tb_uart_rx_framer;

   logic       clk_i = 1'b0;
   logic       nrst_i;
   logic       tick_i;
   logic       rxd_i;
   logic [1:0] wls_i;
   logic       pen_i;
   logic       eps_i;
   logic       sp_i;
   logic [7:0] data_o;
   logic       valid_o;
   logic       perr_o;
   logic       ferr_o;
   logic       brk_o;
   logic       busy_o;

   int total = 0;
   int bad   = 0;

   // valid_o monitor: counts strobes and captures the qualified outputs
   int         vcnt = 0;
   logic [7:0] cap_data = '0;
   logic       cap_perr = 1'b0;
   logic       cap_ferr = 1'b0;
   logic       cap_brk  = 1'b0;

   // valid_o seen right after / one cycle after the mid-stop tick
   logic mid_v;
   logic post_v;

   uart_rx_framer dut (
      .clk_i   (clk_i),
      .nrst_i  (nrst_i),
      .tick_i  (tick_i),
      .rxd_i   (rxd_i),
      .wls_i   (wls_i),
      .pen_i   (pen_i),
      .eps_i   (eps_i),
      .sp_i    (sp_i),
      .data_o  (data_o),
      .valid_o (valid_o),
      .perr_o  (perr_o),
      .ferr_o  (ferr_o),
      .brk_o   (brk_o),
      .busy_o  (busy_o)
   );

   always #5 clk_i = ~clk_i;

   always @(negedge clk_i) begin
      if (valid_o === 1'b1) begin
         vcnt++;
         cap_data = data_o;
         cap_perr = perr_o;
         cap_ferr = ferr_o;
         cap_brk  = brk_o;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // One tick pulse followed by two quiet cycles; ends on a negedge
   task automatic do_tick();
      @(negedge clk_i) tick_i = 1'b1;
      @(negedge clk_i) tick_i = 1'b0;
      @(negedge clk_i);
   endtask

   task automatic send_bit(input logic b);
      rxd_i = b;
      repeat (16) do_tick();
   endtask

   task automatic idle(input int n);
      rxd_i = 1'b1;
      repeat (n) do_tick();
   endtask

   // Full frame; scramble rewrites the config after the start bit to prove it is latched
   task automatic send_frame(input logic [7:0] d, input int n, input logic has_par,
                             input logic par, input logic stopv, input logic scramble);
      logic [7:0] dv;
      dv = d;
      send_bit(1'b0);
      if (scramble) begin
         wls_i = 2'b00;
         pen_i = 1'b1;
         sp_i  = 1'b1;
      end
      for (int i = 0; i < n; i++) send_bit(dv[i]);
      if (has_par) send_bit(par);
      rxd_i = stopv;
      for (int i = 0; i < 16; i++) begin
         if (i == 8) begin
            @(negedge clk_i) tick_i = 1'b1;
            @(negedge clk_i) tick_i = 1'b0;
            mid_v = valid_o;
            @(negedge clk_i);
            post_v = valid_o;
         end else begin
            do_tick();
         end
      end
   endtask

   task automatic set_cfg(input logic [1:0] w, input logic p, input logic e, input logic s);
      wls_i = w;
      pen_i = p;
      eps_i = e;
      sp_i  = s;
   endtask

   int base;

   initial begin
      nrst_i = 1'b0;
      tick_i = 1'b0;
      rxd_i  = 1'b1;
      set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
      repeat (3) @(negedge clk_i);
      check("rst_data",  data_o,  8'h00);
      check("rst_valid", valid_o, 1'b0);
      check("rst_flags", {perr_o, ferr_o, brk_o}, 3'b000);
      check("rst_busy",  busy_o,  1'b0);
      nrst_i = 1'b1;
      idle(4);

      // 8N1 0xA5, config scrambled mid-frame must not matter
      base = vcnt;
      send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b1);
      idle(4);
      check("a5_count", vcnt - base, 1);
      check("a5_data",  cap_data, 8'hA5);
      check("a5_flags", {cap_perr, cap_ferr, cap_brk}, 3'b000);
      check("a5_valid_after_mid", mid_v, 1'b1);
      check("a5_valid_one_cycle", post_v, 1'b0);

      // 7E1 0x35 (four ones): parity bit 0 is correct, 1 is an error
      set_cfg(2'b10, 1'b1, 1'b1, 1'b0);
      send_frame(8'h35, 7, 1'b1, 1'b0, 1'b1, 1'b0);
      idle(4);
      check("7e1_data",  cap_data, 8'h35);
      check("7e1_perr0", cap_perr, 1'b0);
      send_frame(8'h35, 7, 1'b1, 1'b1, 1'b1, 1'b0);
      idle(4);
      check("7e1_data_b", cap_data, 8'h35);
      check("7e1_perr1",  cap_perr, 1'b1);
      check("7e1_ferr",   cap_ferr, 1'b0);

      // 5-bit stick parity, eps=0: expected parity bit is 1
      set_cfg(2'b00, 1'b1, 1'b0, 1'b1);
      send_frame(8'h1F, 5, 1'b1, 1'b0, 1'b1, 1'b0);
      idle(4);
      check("stick_data", cap_data, 8'h1F);
      check("stick_perr", cap_perr, 1'b1);

      // Five-tick low glitch: false start seen at the mid-start tick
      set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
      base = vcnt;
      rxd_i = 1'b0;
      repeat (5) do_tick();
      rxd_i = 1'b1;
      repeat (3) do_tick();
      check("glitch_busy_pre",  busy_o, 1'b1);
      do_tick();
      check("glitch_busy_post", busy_o, 1'b0);
      idle(40);
      check("glitch_no_valid", vcnt - base, 0);

      // Line low through two frames, released just after the second stop sample
      base = vcnt;
      rxd_i = 1'b0;
      repeat (306) do_tick();
`ifdef UART_RX_BREAK_DETECT_EN
      check("brk_count", vcnt - base, 1);
      check("brk_flag",  cap_brk, 1'b1);
`else
      check("brk_count", vcnt - base, 2);
      check("brk_flag",  cap_brk, 1'b0);
`endif
      check("brk_data", cap_data, 8'h00);
      check("brk_ferr", cap_ferr, 1'b1);
      idle(8);
      send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(4);
      check("post_brk_data",  cap_data, 8'h5A);
      check("post_brk_flags", {cap_perr, cap_ferr, cap_brk}, 3'b000);

      // Reset during data bit 3 of 0x3C, then a clean 0xC3
      base = vcnt;
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b1);
      rxd_i = 1'b1;
      repeat (5) do_tick();
      @(negedge clk_i) nrst_i = 1'b0;
      #1;
      check("midrst_busy",  busy_o, 1'b0);
      check("midrst_data",  data_o, 8'h00);
      check("midrst_valid", valid_o, 1'b0);
      @(negedge clk_i) nrst_i = 1'b1;
      idle(20);
      send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(20);
      check("midrst_count", vcnt - base, 1);
      check("midrst_c3",    cap_data, 8'hC3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
